// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared state encoding, table entry layout and a table helper
// for the codec configuration sequencer.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } cfg_state_t;

  // Table entry layout: {reg_addr[6:0], reg_val[8:0]}
  localparam int ENTRY_W     = 16;
  localparam int REG_ADDR_HI = 15;
  localparam int REG_ADDR_LO = 9;
  localparam int REG_VAL_HI  = 8;
  localparam int REG_VAL_LO  = 0;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [6:0] reg_addr,
                                                  input logic [8:0] reg_val);
    return {reg_addr, reg_val};
  endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// codec_reg_rom: WM8731 bring-up table, combinational lookup by index.
// Indices past the populated table return an all-zero entry.
module codec_reg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]         i_idx,
  output logic [ENTRY_W-1:0] o_entry
);

  // Table lookup; the codec is kept inactive while the path is configured
  always_comb begin
    o_entry = '0;
    case (i_idx)
      4'd0:    o_entry = mk_entry(7'h0F, 9'h000); // reset
      4'd1:    o_entry = mk_entry(7'h09, 9'h000); // inactive during setup
      4'd2:    o_entry = mk_entry(7'h00, 9'h117); // line-in, both channels, 0 dB
      4'd3:    o_entry = mk_entry(7'h02, 9'h179); // headphone, both channels, 0 dB
      4'd4:    o_entry = mk_entry(7'h04, 9'h012); // analog path: DAC select, line-in
      4'd5:    o_entry = mk_entry(7'h05, 9'h000); // digital path: no de-emph, unmuted
      4'd6:    o_entry = mk_entry(7'h06, 9'h000); // power: everything on
      4'd7:    o_entry = mk_entry(7'h07, 9'h00A); // interface: I2S, 24-bit, slave
      4'd8:    o_entry = mk_entry(7'h08, 9'h000); // sampling: normal mode, 48 kHz
      4'd9:    o_entry = mk_entry(7'h09, 9'h001); // active
      default: o_entry = '0;
    endcase
  end

endmodule

// File: rtl/codec_config_seq.sv
// codec_config_seq: walks the codec register table and issues one I2C write
// request per entry, pacing writes with an idle gap.
// Optional feature macro CODEC_CFG_RETRY_EN: when defined, a NACKed write is
// re-issued (after the gap) up to MAX_RETRIES more times before giving up;
// when undefined the first NACK ends the pass in ERROR.
module codec_config_seq
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         NUM_REGS    = 10,
  parameter int         GAP_CYCLES  = 16,
  parameter int         MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       i2c_req,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data1,
  output logic [7:0] i2c_data2,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  output logic       busy,
  output logic       config_done,
  output logic       config_err,
  output logic [3:0] err_index
);

  // Elaboration-time range guards
  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("NUM_REGS out of range 1..16");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("GAP_CYCLES out of range 0..65535");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_bad_retries
    $error("MAX_RETRIES out of range 1..7");
  end

  localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
  localparam bit          SKIP_GAP = (GAP_CYCLES == 0);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  cfg_state_t         r_state;
  logic [3:0]         r_idx;
  logic [15:0]        r_gap;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [3:0]         r_eidx;
  logic [7:0]         r_d1;
  logic [7:0]         r_d2;
`ifdef CODEC_CFG_RETRY_EN
  localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);
  logic [2:0]         r_retry;
`endif

  logic [ENTRY_W-1:0] w_entry;
  logic [7:0]         w_d1;
  logic [7:0]         w_d2;

  codec_reg_rom u_rom (
    .i_idx   (r_idx),
    .o_entry (w_entry)
  );

  assign w_d1 = {w_entry[REG_ADDR_HI:REG_ADDR_LO], w_entry[REG_VAL_HI]};
  assign w_d2 = w_entry[REG_VAL_LO+7:REG_VAL_LO];

  // Sequencer FSM; every output is a register updated on the transition
  // into the state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_eidx  <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
`ifdef CODEC_CFG_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_d1    <= w_d1;
          r_d2    <= w_d2;
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (i2c_done) begin
            r_req <= 1'b0;
            if (!i2c_ack_err) begin
`ifdef CODEC_CFG_RETRY_EN
              r_retry <= '0;
`endif
              if (r_idx == LAST_IDX) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_gap   <= '0;
                r_state <= SKIP_GAP ? S_LOAD : S_GAP;
              end
`ifdef CODEC_CFG_RETRY_EN
            end else if (r_retry < MAX_R) begin
              // same idx goes out again after the gap
              r_retry <= r_retry + 3'd1;
              r_gap   <= '0;
              r_state <= SKIP_GAP ? S_LOAD : S_GAP;
`endif
            end else begin
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
              r_eidx  <= r_idx;
              r_state <= S_ERROR;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_eidx  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
`ifdef CODEC_CFG_RETRY_EN
            r_retry <= '0;
`endif
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c_req     = r_req;
  assign i2c_addr    = DEV_ADDR;
  assign i2c_data1   = r_d1;
  assign i2c_data2   = r_d2;
  assign busy        = r_busy;
  assign config_done = r_done;
  assign config_err  = r_err;
  assign err_index   = r_eidx;

endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq: randomized bench for codec_config_seq. A downstream
// I2C model answers requests with random latency and a scripted ACK/NACK
// sequence; a transaction-level model predicts the write order and outcome.
module tb_codec_config_seq;

  localparam int GAP  = 4;
  localparam int NREG = 10;
  localparam int MAXR = 3;
`ifdef CODEC_CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start_m, start_s, w_start;
  logic       i2c_req, i2c_done, i2c_ack_err;
  logic [7:0] i2c_addr, i2c_data1, i2c_data2;
  logic       busy, config_done, config_err;
  logic [3:0] err_index;

  assign w_start = start_m | start_s;

  codec_config_seq #(
    .DEV_ADDR(8'h34), .NUM_REGS(NREG), .GAP_CYCLES(GAP), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .start(w_start),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr),
    .i2c_data1(i2c_data1), .i2c_data2(i2c_data2),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .busy(busy), .config_done(config_done), .config_err(config_err),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  // Expected register writes as (register, value) pairs
  int t_addr [NREG] = '{15, 9, 0, 2, 4, 5, 6, 7, 8, 9};
  int t_val  [NREG] = '{'h000, 'h000, 'h117, 'h179, 'h012, 'h000, 'h000, 'h00A, 'h000, 'h001};

  int n_chk = 0, n_pass = 0;

  bit         resp_q[$];
  logic [7:0] got1_q[$], got2_q[$];
  int         gap_q[$];
  int         stab_err = 0;
  bit         stray_en = 0;
  int         min_dly = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Downstream I2C writer: records each request, answers after a random
  // latency, measures the idle gap to the next request and injects stray
  // start (while busy in a transfer) and stray done (while idle) pulses.
  initial begin : responder
    int dly, g;
    logic [7:0] d1, d2;
    bit nack;
    i2c_done = 0; i2c_ack_err = 0; start_s = 0;
    forever begin
      @(negedge clk);
      if (i2c_req && !reset) begin
        d1 = i2c_data1; d2 = i2c_data2;
        got1_q.push_back(d1); got2_q.push_back(d2);
        dly = $urandom_range(min_dly, min_dly + 4);
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          start_s = stray_en && ($urandom_range(0, 2) == 0);
          if (i2c_req && !reset && (i2c_data1 != d1 || i2c_data2 != d2)) stab_err++;
        end
        start_s = 0;
        if (i2c_req && !reset) begin
          nack = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
          i2c_done = 1; i2c_ack_err = nack;
          @(negedge clk);
          i2c_done = 0; i2c_ack_err = 0;
          g = 0;
          while (!i2c_req && g < 20) begin
            @(negedge clk);
            g++;
            if (g == 2 && stray_en) begin
              i2c_done = 1; i2c_ack_err = 1'($urandom_range(0, 1));
            end else begin
              i2c_done = 0; i2c_ack_err = 0;
            end
          end
          i2c_done = 0; i2c_ack_err = 0;
          if (i2c_req) gap_q.push_back(g);
        end
      end
    end
  end

  // One configuration pass: predict from the response script, then run it
  task automatic run_pass(input string tag);
    int  exp_idx[$];
    int  idx, tries, ri, k;
    bit  nack, e_done, e_err;
    int  e_eidx;
    idx = 0; tries = 0; ri = 0; e_done = 0; e_err = 0; e_eidx = 0;
    forever begin
      exp_idx.push_back(idx);
      nack = (ri < resp_q.size()) ? resp_q[ri] : 1'b0;
      ri++;
      if (!nack) begin
        tries = 0;
        if (idx == NREG - 1) begin e_done = 1; break; end
        idx++;
      end else if (RETRY && tries < MAXR) begin
        tries++;
      end else begin
        e_err = 1; e_eidx = idx; break;
      end
    end

    got1_q.delete(); got2_q.delete(); gap_q.delete(); stab_err = 0;
    @(negedge clk); start_m = 1;
    @(posedge clk); #1; start_m = 0;
    chk({tag, "_busy_up"}, busy, 1);
    chk({tag, "_flags_clr"}, {config_done, config_err}, 0);
    for (int c = 0; c < 4000 && busy; c++) @(negedge clk);
    chk({tag, "_finish"}, busy, 0);
    repeat (25) @(negedge clk);

    chk({tag, "_n_xfer"}, got1_q.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < got1_q.size(); i++) begin
      k = exp_idx[i];
      chk($sformatf("%s_d1[%0d]", tag, i), got1_q[i], ((t_addr[k] << 1) | (t_val[k] >> 8)) & 'hFF);
      chk($sformatf("%s_d2[%0d]", tag, i), got2_q[i], t_val[k] & 'hFF);
    end
    chk({tag, "_n_gap"}, gap_q.size(), exp_idx.size() - 1);
    foreach (gap_q[i]) chk($sformatf("%s_gap[%0d]", tag, i), gap_q[i], GAP + 1);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_done"}, config_done, e_done);
    chk({tag, "_err"}, config_err, e_err);
    if (e_err) chk({tag, "_eidx"}, err_index, e_eidx);
    chk({tag, "_req_low"}, i2c_req, 0);
    chk({tag, "_addr"}, i2c_addr, 'h34);
    resp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, i2c_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, config_done, 0);
    chk({tag, "_err"}, config_err, 0);
    chk({tag, "_eidx"}, err_index, 0);
    chk({tag, "_d1"}, i2c_data1, 0);
    chk({tag, "_d2"}, i2c_data2, 0);
    chk({tag, "_addr"}, i2c_addr, 'h34);
  endtask

  initial begin : main
    reset = 1; start_m = 0;
    repeat (3) @(negedge clk);
    start_m = 1; @(negedge clk); start_m = 0;   // start under reset is ignored
    chk_reset_vals("por");
    reset = 0;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_req", i2c_req, 0);

    stray_en = 1;
    run_pass("clean");
    run_pass("restart");

    resp_q = '{0, 0, 0, 1};
    run_pass("nack3");

    resp_q = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    run_pass("persist5");

    // Reset while the third write (idx 2) is outstanding
    stray_en = 0; min_dly = 3; resp_q.delete();
    got1_q.delete(); got2_q.delete();
    @(negedge clk); start_m = 1;
    @(posedge clk); #1; start_m = 0;
    for (int c = 0; c < 500 && got1_q.size() < 3; c++) @(negedge clk);
    chk("rst_reach_idx2", got1_q.size(), 3);
    if (got1_q.size() >= 3) chk("rst_idx2_d1", got1_q[2], ((t_addr[2] << 1) | (t_val[2] >> 8)) & 'hFF);
    @(negedge clk);
    chk("rst_mid_wait", i2c_req, 1);
    reset = 1; #1;
    chk_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    reset = 0;
    repeat (30) @(negedge clk);
    chk("rst_stay_idle", busy, 0);
    min_dly = 0; stray_en = 1;
    run_pass("after_rst");

    for (int p = 0; p < 4; p++) begin
      resp_q.delete();
      for (int i = 0; i < 40; i++) resp_q.push_back($urandom_range(0, 4) == 0);
      run_pass($sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/codec_config_seq.md
CODEC_CONFIG_SEQ -- requirements
Module: codec_config_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h34, meaning the 8-bit codec I2C write address byte.
REQ-002 SHALL have parameter NUM_REGS, default 10, meaning the number of register writes in the table (1..16).
REQ-003 SHALL have parameter GAP_CYCLES, default 16, meaning the idle clk cycles inserted between consecutive writes (0..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning the extra attempts per write after a NACK (1..7).
REQ-005 SHALL have port clk  input  1  sole clock; all logic rises on posedge clk.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle pulse that begins a full configuration pass.
REQ-008 SHALL have port i2c_req  output  1  transfer request to the downstream I2C writer, held until i2c_done.
REQ-009 SHALL have port i2c_addr  output  8  chip address byte (DEV_ADDR).
REQ-010 SHALL have port i2c_data1  output  8  {reg_addr[6:0], reg_val[8]}.
REQ-011 SHALL have port i2c_data2  output  8  reg_val[7:0].
REQ-012 SHALL have port i2c_done  input  1  one-cycle pulse marking the end of a transfer (stop sent or aborted).
REQ-013 SHALL have port i2c_ack_err  input  1  NACK flag, sampled only in the cycle i2c_done is high.
REQ-014 SHALL have port busy  output  1  high from start acceptance until DONE or ERROR.
REQ-015 SHALL have port config_done  output  1  sticky high after all NUM_REGS writes are ACKed.
REQ-016 SHALL have port config_err  output  1  sticky high when a write fails.
REQ-017 SHALL have port err_index  output  4  table index of the failing write.

Function
REQ-018 SHALL implement states IDLE, LOAD, REQ, WAIT, GAP, DONE and ERROR.
REQ-019 SHALL go from IDLE to LOAD on start; in DONE or ERROR, start SHALL clear the flags, set idx=0 and go to LOAD; start SHALL be ignored in all other states.
REQ-020 SHALL, in LOAD, register the table entry at idx onto i2c_data1/2 and go to REQ the next cycle, with data held stable while i2c_req=1.
REQ-021 SHALL assert i2c_req in REQ and WAIT only; REQ SHALL pass to WAIT after one cycle.
REQ-022 SHALL, on i2c_done with i2c_ack_err=0, clear the retry count; if idx==NUM_REGS-1 it SHALL go to DONE, otherwise it SHALL increment idx and go to GAP.
REQ-023 SHALL count GAP_CYCLES cycles in GAP, then go to LOAD, and SHALL skip GAP entirely when GAP_CYCLES=0.
REQ-024 SHALL ignore an i2c_done pulse outside WAIT.
REQ-025 SHALL never let idx wrap: no increment past NUM_REGS-1.
REQ-026 SHALL decode the 16-bit table entry as {reg_addr[6:0], reg_val[8:0]}.
REQ-027 SHALL assert busy=1 in LOAD, REQ, WAIT and GAP, and busy=0 in IDLE, DONE and ERROR.

Reset
REQ-028 SHALL, on reset assertion at any time (including mid-transfer), immediately go to IDLE with i2c_req=0, busy=0, config_done=0, config_err=0, err_index=0, idx=0, retry count=0, gap counter=0, i2c_data1/2=0 and i2c_addr=DEV_ADDR.
REQ-029 SHALL hold all outputs at their reset values while reset=1 and SHALL leave IDLE only on the first start after release.

Configuration
REQ-030 SHALL, with CODEC_CFG_RETRY_EN defined, respond to i2c_done with i2c_ack_err=1 by going to GAP and then re-issuing the same idx while retries<MAX_RETRIES, and by going to ERROR with err_index=idx once retries are exhausted.
REQ-031 SHALL, without CODEC_CFG_RETRY_EN, respond to the first NACK by going directly to ERROR with err_index=idx, with no retry counter logic present.

Structure
REQ-032 SHALL place state encodings, the table entry width (16) and the field slice constants in package codec_cfg_pkg.
REQ-033 SHALL hold the register table in sub-module codec_reg_rom, a combinational lookup from idx[3:0] to a 16-bit entry (WM8731 defaults: reset, line-in, headphone, analog path, digital path, power, interface, sampling, active), returning 16'h0000 for out-of-range idx.

Verification
REQ-034 SHALL verify a clean pass: start, downstream model ACKs every write, GAP_CYCLES=4 -> exactly 10 i2c_req handshakes, i2c_data1/2 matching the ROM, then config_done=1, busy=0.
REQ-035 SHALL verify a single NACK with retry enabled: NACK on idx 3 then ACK -> idx 3 sent twice, pass completes with config_done=1.
REQ-036 SHALL verify persistent NACK: NACK on idx 5 always -> with the macro, 4 attempts then config_err=1, err_index=5; without it, 1 attempt then ERROR.
REQ-037 SHALL verify reset mid-WAIT: assert reset on idx 2 -> i2c_req=0 the same cycle, all outputs at reset values, a later start restarts at idx 0.
REQ-038 SHALL verify stray inputs: start during WAIT and i2c_done during GAP -> no state, idx or output change.
REQ-039 SHALL verify a restart: start in DONE -> config_done cleared the next cycle, full pass repeats.
